dff_checker: RTL and testbench
==============================

DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of counters and cycle stamp.
REQ-002 Parameter FIFO_DEPTH, default 4, mismatch-record buffer depth (power of 2).
REQ-003 Parameter STOP_ON_ERR, default 0; when 1, the first mismatch halts checking.
REQ-004 Port clk  input  1  checker clock, the same clock that drives the DFF bench.
REQ-005 Port rst_n  input  1  checker reset, asynchronous, active-low.
REQ-006 Port en  input  1  enable checking.
REQ-007 Port dut_rst_n  input  1  observed DUT reset.
REQ-008 Port d  input  1  observed DUT data input.
REQ-009 Port q  input  1  observed DUT output.
REQ-010 Port cnt_clr  input  1  synchronous clear of counters, overflow and stamp.
REQ-011 Port match_cnt  output  CNT_W  saturating count of passing compares.
REQ-012 Port mismatch_cnt  output  CNT_W  saturating count of failing compares.
REQ-013 Port state  output  2  current FSM state.
REQ-014 Port err_valid  output  1  mismatch record available.
REQ-015 Port err_ready  input  1  consumer accepts the record.
REQ-016 Port err_data  output  CNT_W+2  record: {stamp, expected, actual}.
REQ-017 Port overflow  output  1  sticky flag; a record was dropped because the FIFO was full.

Function
REQ-018 All inputs SHALL be sampled on posedge clk; the sampled values are d_s, q_s and dut_rst_n_s.
REQ-019 The prediction register pred SHALL load (dut_rst_n_s ? d_s : 0) on every edge in SYNC or CHECK.
REQ-020 The expected value SHALL be exp = (!dut_rst_n_s) ? 0 : pred, so an asynchronous DUT reset forces the expected value to 0 on the same edge.
REQ-021 The FSM SHALL have states IDLE=0, SYNC=1, CHECK=2 and HALT=3.
REQ-022 IDLE -> SYNC when en=1; SYNC -> CHECK after exactly one edge (pred loaded, no compare).
REQ-023 In CHECK, the block SHALL compare q_s against exp every edge and increment match_cnt or mismatch_cnt.
REQ-024 CHECK -> HALT on a mismatch when STOP_ON_ERR=1; the mismatch that triggers the halt is still counted and logged.
REQ-025 Any state -> IDLE when en=0; HALT is exited only through en=0.
REQ-026 Counters SHALL saturate at all-ones with no wrap.
REQ-027 The cycle stamp SHALL increment every edge in CHECK and wrap modulo 2^CNT_W.
REQ-028 Each mismatch SHALL push {stamp, exp, q_s} into the FIFO; the record is visible on err_valid one cycle later.
REQ-029 The err handshake SHALL be valid/ready: a pop occurs when err_valid && err_ready, and err_data is held stable while err_valid=1 and err_ready=0.
REQ-030 Push with the FIFO full and no simultaneous pop: the record SHALL be dropped and overflow set. Push with the FIFO full and a simultaneous pop: both SHALL occur with no drop.
REQ-031 cnt_clr SHALL clear match_cnt, mismatch_cnt, stamp and overflow; a clear takes priority over an increment in the same cycle; the FIFO contents are retained.

Reset
REQ-032 On rst_n=0 the block SHALL asynchronously set state=IDLE, counters=0, stamp=0, pred=0, FIFO empty, err_valid=0 and overflow=0.
REQ-033 A reset in the middle of CHECK SHALL discard all pending records; after release the block restarts through IDLE/SYNC.

Structure
REQ-034 Package dff_chk_pkg SHALL hold the state enum, the mismatch record struct and the default widths.
REQ-035 The FIFO SHALL be a sub-module named dff_chk_fifo (parameterised width/depth, valid/ready pop, full/empty outputs).

Verification
REQ-036 Scenario: en=1, d toggles 0,1,1,0 with a correct DFF model -> after 4 CHECK edges, match_cnt=4, mismatch_cnt=0, err_valid=0.
REQ-037 Scenario: force q inverted on one CHECK edge at stamp=5 -> mismatch_cnt=1, err_data={5,1,0} (or {5,0,1}), err_valid held until err_ready.
REQ-038 Scenario: err_ready=0 with 5 consecutive mismatches -> 4 records buffered, overflow=1, mismatch_cnt=5.
REQ-039 Scenario: dut_rst_n pulsed low mid-stream with d=1 -> expected=0 on that edge, no mismatch for a correct DUT.
REQ-040 Scenario: STOP_ON_ERR=1, one mismatch -> state=HALT, counters frozen; en=0 -> IDLE.
REQ-041 Scenario: CNT_W=4 with 20 matches -> match_cnt=15; cnt_clr on the same edge as a match -> match_cnt=0.

Source files
------------

// File: rtl/dff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_pkg
// Purpose  : Shared types and default widths for the DFF checker slice.
// Revision : 1.0
// ============================================================================
package dff_chk_pkg;

  localparam int c_def_cnt_w      = 16;
  localparam int c_def_fifo_depth = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } chk_state_e;

  // Layout of one mismatch record at the default counter width.
  typedef struct packed {
    logic [c_def_cnt_w-1:0] stamp;
    logic                   expected;
    logic                   actual;
  } mism_rec_t;

endpackage

`default_nettype wire

// File: rtl/dff_chk_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_fifo
// Purpose  : Small synchronous FIFO with valid/ready pop and full/empty flags.
// Revision : 1.0
// ============================================================================
module dff_chk_fifo
  import dff_chk_pkg::*;
#(
  parameter int WIDTH = c_def_cnt_w + 2,
  parameter int DEPTH = c_def_fifo_depth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int                c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]     c_full    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]     c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0]   c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_aw:0]    count_q;

  logic w_push;
  logic w_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == c_full);
  assign pop_valid_o = ~empty_o;
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign w_pop       = ~empty_o && pop_ready_i;
  // A pop in the same cycle frees the slot the push is about to use.
  assign w_push      = push_i && (~full_o || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_one;
      end
      unique case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_cnt_one;
        2'b01:   count_q <= count_q - c_cnt_one;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : dff_checker
// Purpose  : Predicts a DFF output one edge ahead, counts compares and logs
//            mismatch records {stamp, expected, actual} into a FIFO.
// Revision : 1.0
// ============================================================================
module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int CNT_W       = c_def_cnt_w,
  parameter int FIFO_DEPTH  = c_def_fifo_depth,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dut_rst_n,
  input  logic             d,
  input  logic             q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [1:0]       state,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [CNT_W+1:0] err_data,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  chk_state_e       state_q;
  logic             pred_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] mismatch_q;
  logic [CNT_W-1:0] stamp_q;
  logic             overflow_q;

  logic             w_checking;
  logic             w_exp;
  logic             w_mis;
  logic             w_hit;
  logic             w_pop;
  logic             w_drop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W+1:0] w_rec;

  // An asserted DUT reset has already cleared q, so the expectation is 0.
  assign w_exp      = dut_rst_n & pred_q;
  assign w_checking = en && (state_q == ST_CHECK);
  assign w_mis      = w_checking && (q != w_exp);
  assign w_hit      = w_checking && (q == w_exp);
  assign w_pop      = ~w_fifo_empty && err_ready;
  assign w_drop     = w_mis && w_fifo_full && ~w_pop;
  assign w_rec      = {stamp_q, w_exp, q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pred_q     <= 1'b0;
      match_q    <= '0;
      mismatch_q <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (!en) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: state_q <= ST_SYNC;
          ST_SYNC: begin
            pred_q  <= dut_rst_n & d;
            state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            pred_q <= dut_rst_n & d;
            if (w_mis && STOP_ON_ERR) begin
              state_q <= ST_HALT;
            end
          end
          default: state_q <= state_q;
        endcase
      end

      if (cnt_clr) begin
        match_q    <= '0;
        mismatch_q <= '0;
        stamp_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (w_hit && (match_q != c_cnt_max)) begin
          match_q <= match_q + c_cnt_one;
        end
        if (w_mis && (mismatch_q != c_cnt_max)) begin
          mismatch_q <= mismatch_q + c_cnt_one;
        end
        if (w_checking) begin
          stamp_q <= stamp_q + c_cnt_one;
        end
        if (w_drop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  dff_chk_fifo #(
    .WIDTH (CNT_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_mis),
    .push_data_i (w_rec),
    .pop_valid_o (err_valid),
    .pop_ready_i (err_ready),
    .pop_data_o  (err_data),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty)
  );

  assign state        = state_q;
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_checker
// Purpose  : Randomised scoreboard bench for dff_checker in three configurations.
// Revision : 1.0
// ============================================================================
module tb_dff_checker;
  import dff_chk_pkg::*;

  localparam int NI = 3;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic en        = 1'b0;
  logic dut_rst_n = 1'b0;
  logic d         = 1'b0;
  logic inj       = 1'b0;
  logic cnt_clr   = 1'b0;
  logic err_ready = 1'b0;
  logic dffq;
  logic q;

  logic [15:0] mc0, mm0, mc1, mm1;
  logic [3:0]  mc2, mm2;
  logic [1:0]  st0, st1, st2;
  logic        ev0, ev1, ev2, ov0, ov1, ov2;
  logic [17:0] ed0, ed1;
  logic [5:0]  ed2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Correct DFF under observation; inj flips its visible output.
  always @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n) dffq <= 1'b0;
    else            dffq <= d;
  end
  assign q = dffq ^ inj;

  dff_checker u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dut_rst_n(dut_rst_n), .d(d), .q(q),
    .cnt_clr(cnt_clr), .match_cnt(mc0), .mismatch_cnt(mm0), .state(st0),
    .err_valid(ev0), .err_ready(err_ready), .err_data(ed0), .overflow(ov0)
  );

  dff_checker #(.STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .en(en), .dut_rst_n(dut_rst_n), .d(d), .q(q),
    .cnt_clr(cnt_clr), .match_cnt(mc1), .mismatch_cnt(mm1), .state(st1),
    .err_valid(ev1), .err_ready(err_ready), .err_data(ed1), .overflow(ov1)
  );

  dff_checker #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en), .dut_rst_n(dut_rst_n), .d(d), .q(q),
    .cnt_clr(cnt_clr), .match_cnt(mc2), .mismatch_cnt(mm2), .state(st2),
    .err_valid(ev2), .err_ready(err_ready), .err_data(ed2), .overflow(ov2)
  );

  int a_mc[NI], a_mm[NI], a_st[NI], a_ev[NI], a_ov[NI], a_ed[NI];
  always_comb begin
    a_mc[0] = int'(mc0); a_mc[1] = int'(mc1); a_mc[2] = int'(mc2);
    a_mm[0] = int'(mm0); a_mm[1] = int'(mm1); a_mm[2] = int'(mm2);
    a_st[0] = int'(st0); a_st[1] = int'(st1); a_st[2] = int'(st2);
    a_ev[0] = int'(ev0); a_ev[1] = int'(ev1); a_ev[2] = int'(ev2);
    a_ov[0] = int'(ov0); a_ov[1] = int'(ov1); a_ov[2] = int'(ov2);
    a_ed[0] = int'(ed0); a_ed[1] = int'(ed1); a_ed[2] = int'(ed2);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cw_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic int stop_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // Reference model: mode 0..3 = idle/sync/check/halt, FIFO as a count,
  // accepted records go to the scoreboard ring sb_mem.
  int m_mode[NI], m_pred[NI], m_mc[NI], m_mm[NI], m_st[NI], m_ov[NI], m_cnt[NI];
  int sb_mem[NI][16];
  int sb_wr[NI];
  int sb_rd[NI];

  task automatic model_step(input int i);
    int mx, e, rec;
    mx = (1 << cw_of(i)) - 1;
    if (m_cnt[i] > 0 && err_ready) m_cnt[i]--;
    if (!en) begin
      m_mode[i] = 0;
    end else if (m_mode[i] == 0) begin
      m_mode[i] = 1;
    end else if (m_mode[i] == 1) begin
      m_pred[i] = dut_rst_n ? int'(d) : 0;
      m_mode[i] = 2;
    end else if (m_mode[i] == 2) begin
      e = dut_rst_n ? m_pred[i] : 0;
      if (int'(q) != e) begin
        m_mm[i] = (m_mm[i] == mx) ? mx : m_mm[i] + 1;
        rec = (m_st[i] << 2) | (e << 1) | int'(q);
        if (m_cnt[i] < 4) begin
          m_cnt[i]++;
          sb_mem[i][sb_wr[i] % 16] = rec;
          sb_wr[i]++;
        end else begin
          m_ov[i] = 1;
        end
        if (stop_of(i) == 1) m_mode[i] = 3;
      end else begin
        m_mc[i] = (m_mc[i] == mx) ? mx : m_mc[i] + 1;
      end
      m_st[i]   = (m_st[i] + 1) % (mx + 1);
      m_pred[i] = dut_rst_n ? int'(d) : 0;
    end
    if (cnt_clr) begin
      m_mc[i] = 0; m_mm[i] = 0; m_st[i] = 0; m_ov[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_mode[i] = 0; m_pred[i] = 0; m_mc[i] = 0; m_mm[i] = 0;
        m_st[i] = 0; m_ov[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  // Monitor: runs after the driver has settled this cycle's inputs.
  always begin
    @(negedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) sb_rd[i] = sb_wr[i];
      chk($sformatf("state[%0d]", i), a_st[i], m_mode[i]);
      chk($sformatf("match_cnt[%0d]", i), a_mc[i], m_mc[i]);
      chk($sformatf("mismatch_cnt[%0d]", i), a_mm[i], m_mm[i]);
      chk($sformatf("overflow[%0d]", i), a_ov[i], m_ov[i]);
      chk($sformatf("err_valid[%0d]", i), a_ev[i], (m_cnt[i] != 0) ? 1 : 0);
      if (a_ev[i] != 0 && sb_rd[i] != sb_wr[i]) begin
        chk($sformatf("err_data[%0d]", i), a_ed[i], sb_mem[i][sb_rd[i] % 16]);
        if (err_ready) sb_rd[i]++;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n, input int rst_at);
    for (int k = 0; k < n; k++) begin
      cyc();
      en        = ($urandom_range(0, 39) != 0);
      d         = $urandom_range(0, 1);
      dut_rst_n = ($urandom_range(0, 9) != 0);
      inj       = ($urandom_range(0, 11) == 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      err_ready = ($urandom_range(0, 2) != 0);
      rst_n     = (k != rst_at);
    end
  endtask

  logic [3:0] pat;

  initial begin
    for (int i = 0; i < NI; i++) begin
      sb_wr[i] = 0;
      sb_rd[i] = 0;
    end
    pat = 4'b0110;
    repeat (3) cyc();
    chk("reset_state", st0, 0);
    chk("reset_match_cnt", mc0, 0);
    chk("reset_err_valid", ev0, 0);
    chk("reset_overflow", ov0, 0);
    rst_n = 1'b1; dut_rst_n = 1'b1; err_ready = 1'b1;

    rand_cycles(400, -1);

    // Clean restart, four passing compares with d = 0,1,1,0.
    cyc(); en = 0; cnt_clr = 1; inj = 0; dut_rst_n = 1; err_ready = 1; d = 0; rst_n = 1;
    cyc(); en = 1; cnt_clr = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      d = pat[k % 4];
    end
    chk("four_match", mc0, 4);
    chk("four_no_mismatch", mm0, 0);
    chk("four_err_valid", ev0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc();
      d = $urandom_range(0, 1);
    end
    chk("twenty_match", mc0, 20);
    chk("small_saturate", mc2, 15);
    cnt_clr = 1;
    cyc(); cnt_clr = 0; d = 1; err_ready = 0;
    chk("clr_beats_inc", mc0, 0);
    chk("clr_beats_inc_small", mc2, 0);

    // Mismatches at stamps 5..9 with the consumer stalled.
    repeat (5) cyc();
    inj = 1;
    repeat (5) cyc();
    inj = 0;
    chk("burst_mismatch_cnt", mm0, 5);
    chk("burst_overflow", ov0, 1);
    chk("burst_err_valid", ev0, 1);
    chk("burst_first_rec", ed0, (5 << 2) | 2);
    chk("small_first_rec", ed2, (5 << 2) | 2);
    chk("halt_state", st1, 3);
    chk("halt_frozen", mm1, 1);
    chk("halt_rec", ed1, (5 << 2) | 2);
    repeat (2) cyc();
    chk("held_rec", ed0, (5 << 2) | 2);
    chk("held_valid", ev0, 1);
    err_ready = 1;
    repeat (6) cyc();
    chk("drained", ev0, 0);

    // DUT reset across an edge with d = 1.
    d = 1; dut_rst_n = 0;
    cyc(); dut_rst_n = 1;
    repeat (2) cyc();
    chk("dut_reset_no_mismatch", mm0, 5);
    en = 0;
    cyc();
    chk("halt_exit", st1, 0);
    en = 1;

    rand_cycles(300, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
